// File: rtl/gray_counter_pkg.sv
// gray_counter_pkg
//   Shared helpers for binary/Gray conversion and the legal width range.
//   The helpers are fixed at WIDTH_MAX bits so they do not depend on any
//   parameter. Narrower callers zero-extend on the way in and truncate on
//   the way out. Zero upper bits decode to zero, so the narrow result
//   stays correct.
//   No ports (package).
package gray_counter_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic logic [WIDTH_MAX-1:0] bin2gray(input logic [WIDTH_MAX-1:0] x);
        return x ^ (x >> 1);
    endfunction

    // Prefix XOR from the MSB down: b[i] = b[i+1] ^ g[i].
    function automatic logic [WIDTH_MAX-1:0] gray2bin(input logic [WIDTH_MAX-1:0] g);
        logic [WIDTH_MAX-1:0] b;
        b[WIDTH_MAX-1] = g[WIDTH_MAX-1];
        for (int i = WIDTH_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_counter_if.sv
// gray_counter_if
//   Control and status bundle of the Gray counter.
//   Control protocol: there is no valid/ready handshake. Every control is
//   sampled on every rising edge of clk with priority rst > load > en.
//   Every status output is registered and is valid one cycle after the
//   controls that produced it.
//   Signals:
//     en, up, load, load_is_gray, load_val : controls (master -> slave)
//     bin_q, gray_q, wrap_q, sat_q          : registered status (slave -> master)
interface gray_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             up;
    logic             load;
    logic             load_is_gray;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q;
    logic             sat_q;

    modport master (
        output en, up, load, load_is_gray, load_val,
        input  bin_q, gray_q, wrap_q, sat_q
    );

    modport slave (
        input  en, up, load, load_is_gray, load_val,
        output bin_q, gray_q, wrap_q, sat_q
    );
endinterface

// File: rtl/gray_counter_gray_to_binary.sv
// gray_to_binary
//   Combinational Gray-to-binary decoder used on the counter's load path.
//   Ports:
//     g : WIDTH-bit Gray input
//     b : WIDTH-bit binary output
module gray_to_binary
    import gray_counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] b
);
    assign b = WIDTH'(gray2bin(WIDTH_MAX'(g)));
endmodule

// File: rtl/gray_counter.sv
// gray_counter
//   Registered up/down counter. It keeps a binary count and presents it in
//   both binary and Gray form. It can load a binary or Gray value
//   synchronously. WRAP selects wrap-around or saturation at the extremes.
//   Ports:
//     clk : rising-edge clock
//     rst : synchronous active-high reset
//     bus : gray_counter_if.slave (controls in, registered status out)
module gray_counter
    import gray_counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter bit WRAP  = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    gray_counter_if.slave bus
);
    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
            $error("gray_counter: WIDTH must be in 2..32");
        end
    endgenerate

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin_n;
    logic             wrap_n;
    logic             sat_n;
    logic [WIDTH-1:0] bin_r;
    logic [WIDTH-1:0] gray_r;
    logic             wrap_r;
    logic             sat_r;

    gray_to_binary #(.WIDTH(WIDTH)) u_g2b (
        .g (bus.load_val),
        .b (load_bin)
    );

    always_comb begin
        bin_n  = bin_r;
        wrap_n = 1'b0;
        sat_n  = 1'b0;
        if (bus.load) begin
            bin_n = bus.load_is_gray ? load_bin : bus.load_val;
        end else if (bus.en) begin
            if (bus.up) begin
                if (bin_r == CNT_MAX) begin
                    if (WRAP) begin
                        bin_n  = '0;
                        wrap_n = 1'b1;
                    end else begin
                        sat_n  = 1'b1;
                    end
                end else begin
                    bin_n = bin_r + WIDTH'(1);
                end
            end else begin
                if (bin_r == '0) begin
                    if (WRAP) begin
                        bin_n  = CNT_MAX;
                        wrap_n = 1'b1;
                    end else begin
                        sat_n  = 1'b1;
                    end
                end else begin
                    bin_n = bin_r - WIDTH'(1);
                end
            end
        end
    end

    // Gray is encoded from the next binary value and then registered.
    // The output therefore never passes through combinational logic after
    // the flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_r  <= '0;
            gray_r <= '0;
            wrap_r <= 1'b0;
            sat_r  <= 1'b0;
        end else begin
            bin_r  <= bin_n;
            gray_r <= bin_n ^ (bin_n >> 1);
            wrap_r <= wrap_n;
            sat_r  <= sat_n;
        end
    end

    assign bus.bin_q  = bin_r;
    assign bus.gray_q = gray_r;
    assign bus.wrap_q = wrap_r;
    assign bus.sat_q  = sat_r;
endmodule
